// File: rtl/dmem_access_controller_if.sv
// ---------------------------------------------------------------------------
// dmem_if: req/ack bus between the MEM-stage access controller and a
// multi-cycle data memory. Signal names carry the controller's view.
//
//   mem_req_o    controller -> memory  transaction request (held until ack)
//   mem_we_o     controller -> memory  1 = write
//   mem_addr_o   controller -> memory  byte address
//   mem_wdata_o  controller -> memory  write data
//   mem_ack_i    memory -> controller  transaction completes this cycle
//   mem_rdata_i  memory -> controller  read data, valid with mem_ack_i
// ---------------------------------------------------------------------------
interface dmem_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/dmem_access_controller.sv
// ---------------------------------------------------------------------------
// dmem_access_controller: freezes the pipeline while the MEM-stage load/store
// runs one req/ack transaction on the data memory, then releases the pipeline
// for exactly one cycle (DONE) so the instruction retires into MEM/WB.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   MemRead_i          MEM-stage instruction is a load
//   MemWrite_i         MEM-stage instruction is a store (wins if both set)
//   Addr_i             byte address from the ALU
//   WriteData_i        store data
//   ReadData_o         registered load data (0 after a timeout)
//   Stall_o            combinational pipeline freeze
//   Timeout_o          sticky: a transaction was aborted
//   mem                dmem_if master: request bus to the data memory
// ---------------------------------------------------------------------------
module dmem_access_controller #(
    parameter int TIMEOUT = 255            // 1..255 WAIT cycles
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] ReadData_o,
    output logic        Stall_o,
    output logic        Timeout_o,
    dmem_if.master      mem
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] TO_CNT = TIMEOUT[7:0];

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        to_q, to_d;

    logic        access;
    logic [7:0]  cnt_inc;
    logic        last_wait;

    assign access    = MemRead_i | MemWrite_i;
    // cnt_q holds completed WAIT cycles, so cnt_inc is the number of the
    // current one; it peaks at TIMEOUT (<=255) and never wraps.
    assign cnt_inc   = cnt_q + 8'd1;
    assign last_wait = (cnt_inc == TO_CNT);

    // State register and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = WAIT;
            WAIT:    if (mem.mem_ack_i || last_wait) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    addr_d  = Addr_i;
                    wdata_d = WriteData_i;
                    we_d    = MemWrite_i;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                // Ack on the last allowed cycle still counts as success
                if (mem.mem_ack_i) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = mem.mem_rdata_i;
                end else if (last_wait) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    to_d    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        Stall_o = ((state_q == IDLE) && access) || (state_q == WAIT);
    end

    assign ReadData_o      = rdata_q;
    assign Timeout_o       = to_q;
    assign mem.mem_req_o   = req_q;
    assign mem.mem_we_o    = we_q;
    assign mem.mem_addr_o  = addr_q;
    assign mem.mem_wdata_o = wdata_q;

endmodule

// File: doc/dmem_access_controller.md
# dmem_access_controller

Sequencer between the MEM stage of the 5-stage pipeline and a multi-cycle data memory with a req/ack handshake. When the MEM-stage instruction loads or stores, it freezes the whole pipeline and launches one memory transaction. It holds the request until acknowledge or timeout, captures read data, then releases the pipeline for exactly one cycle so the instruction can retire into MEM/WB. Its stall output is ORed with the load-use stall by the top level.

## Interface
Parameters:
- TIMEOUT, 255: maximum WAIT cycles without mem_ack_i before abort; legal range 1..255.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- MemRead_i  in  1  MEM-stage instruction is a load
- MemWrite_i  in  1  MEM-stage instruction is a store
- Addr_i  in  32  MEM-stage ALU result (byte address)
- WriteData_i  in  32  MEM-stage store data
- ReadData_o  out  32  load data to MEM/WB; registered
- Stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- mem_req_o  out  1  transaction request; registered
- mem_we_o  out  1  1 = write; registered
- mem_addr_o  out  32  latched address; registered
- mem_wdata_o  out  32  latched write data; registered
- mem_ack_i  in  1  memory completes transaction this cycle
- mem_rdata_i  in  32  read data, valid when mem_ack_i=1
- Timeout_o  out  1  sticky: some transaction timed out

## Operation
- States: IDLE, WAIT, DONE. Encoding is free.
- access = MemRead_i | MemWrite_i. If both are 1, the transaction is a write (mem_we_o=1).
- IDLE:
  - If access=1: latch Addr_i, WriteData_i and MemWrite_i into mem_addr_o, mem_wdata_o and mem_we_o.
  - Also set mem_req_o<=1, clear the wait counter, and go to WAIT.
  - If access=0: stay in IDLE. Outputs hold their values.
- WAIT:
  - mem_req_o and the address/data/we registers are held stable.
  - Wait counter increments every WAIT cycle; the first WAIT cycle counts as 1.
  - mem_ack_i=1: mem_req_o<=0. If mem_we_o=0, ReadData_o<=mem_rdata_i; a write leaves ReadData_o unchanged. Go to DONE.
  - No ack on the TIMEOUT-th WAIT cycle: mem_req_o<=0, ReadData_o<=0, Timeout_o<=1, go to DONE.
  - Ack on the TIMEOUT-th cycle counts as normal completion; Timeout_o is not set.
- DONE: the pipeline advances this cycle. Unconditionally go to IDLE. A new access is evaluated in IDLE on the next cycle.
- Stall_o = (state==IDLE & access) | (state==WAIT). It is combinational and 0 in DONE.
- mem_ack_i is ignored in IDLE and DONE.
- Timeout_o is cleared only by rst_i.
- Counter width: 8 bits. It must not wrap before TIMEOUT.

## Timing
- Reset (rst_i=1 at an edge), from any state including mid-transaction:
  - state=IDLE, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, ReadData_o=0, Timeout_o=0, counter=0.
  - A pending memory transaction is abandoned.
- Stall_o during reset is decoded from the current state, so it is 0 once the state is IDLE with no access.
- Cycle N, IDLE with access: Stall_o=1 in the same cycle.
- Cycle N+1: mem_req_o=1 (WAIT).
- Ack in cycle N+k (k≥1): DONE in N+k+1 with ReadData_o valid and Stall_o=0.
- Total stall = k+1 cycles; minimum 2 (ack in the first WAIT cycle).
- Timeout: the last request cycle is N+TIMEOUT. DONE is in N+TIMEOUT+1 with Timeout_o=1.
- Back-to-back memory instructions: DONE, then IDLE with the next access. At least one cycle gap between mem_req_o pulses.

## Test plan
- Load, ack in first WAIT cycle:
  - Stimulus: MemRead_i=1, Addr_i=0x100, mem_rdata_i=0xDEADBEEF.
  - Required: Stall_o=1 for 2 cycles, mem_req_o high for 1 cycle with mem_we_o=0 and mem_addr_o=0x100. In DONE, ReadData_o=0xDEADBEEF and Stall_o=0.
- Store, ack after 3 WAIT cycles:
  - Stimulus: MemWrite_i=1, Addr_i=0x20, WriteData_i=0x55.
  - Required: mem_we_o=1, mem_wdata_o=0x55 stable 3 cycles, Stall_o=1 for 4 cycles, ReadData_o unchanged.
- Timeout with TIMEOUT=4, ack never asserted:
  - Required: mem_req_o high 4 cycles, then ReadData_o=0 and Timeout_o=1. Timeout_o stays 1 through later good transactions until rst_i.
- Ack on exactly the 4th WAIT cycle with TIMEOUT=4:
  - Required: ReadData_o=mem_rdata_i and Timeout_o=0.
- Back-to-back loads, both acked immediately:
  - Required: mem_req_o pulses separated by 2 cycles (DONE, IDLE). Stall_o pattern 1,1,0,1,1,0.
- Reset mid-transaction: rst_i in the 2nd WAIT cycle.
  - Required: next cycle state=IDLE, mem_req_o=0, all outputs at reset values. A late mem_ack_i is ignored.
